seq_divider: RTL

//   Iterative unsigned restoring divider for the CPU datapath: q = a / b, r = a % b.

---
 rtl/div_pkg.sv | 19 +
 rtl/div_step.sv | 29 ++
 rtl/seq_divider.sv | 122 ++++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// ============================================================================
// div_pkg: shared state encodings and default width for the sequential divider
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

package div_pkg;

  localparam int C_DEFAULT_N = 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

endpackage

`default_nettype wire

// File: rtl/div_step.sv
// ============================================================================
// div_step: one restoring shift-subtract step of the unsigned divider
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module div_step #(
  parameter int N = 8
) (
  input  logic [N-1:0] p,
  input  logic         d_msb,
  input  logic [N-1:0] b,
  output logic [N-1:0] p_next,
  output logic         q_bit
);

  logic [N:0]   w_t;
  logic [N+1:0] w_sub;

  // One extra bit on the subtract exposes the borrow-out; clear means T >= B.
  assign w_t    = {p, d_msb};
  assign w_sub  = {1'b0, w_t} - {2'b00, b};
  assign q_bit  = ~w_sub[N+1];
  // Either way the new remainder is below B, so N bits always suffice.
  assign p_next = q_bit ? w_sub[N-1:0] : w_t[N-1:0];

endmodule

`default_nettype wire

// File: rtl/seq_divider.sv
// ============================================================================
// seq_divider: iterative unsigned restoring divider, q = a / b, r = a % b
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_divider
  import div_pkg::*;
#(
  parameter int N    = C_DEFAULT_N,
  parameter int CNTW = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] q,
  output logic [N-1:0] r,
  output logic         dbz
);

  state_e            state_q, state_d;
  logic [N-1:0]      d_q, d_d;
  logic [N-1:0]      b_q, b_d;
  logic [N-1:0]      p_q, p_d;
  logic [N-1:0]      quo_q, quo_d;
  logic [N-1:0]      rem_q, rem_d;
  logic              dbz_q, dbz_d;
  logic [CNTW-1:0]   cnt_q, cnt_d;

  logic [N-1:0]      step_p;
  logic              step_bit;
  logic [N-1:0]      d_shift;

  div_step #(.N(N)) u_step (
    .p      (p_q),
    .d_msb  (d_q[N-1]),
    .b      (b_q),
    .p_next (step_p),
    .q_bit  (step_bit)
  );

  // Dividend bits leave at the top while quotient bits enter at the bottom.
  assign d_shift = {d_q[N-2:0], step_bit};

  always_comb begin
    state_d = state_q;
    d_d     = d_q;
    b_d     = b_q;
    p_d     = p_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    cnt_d   = cnt_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (start) begin
          if (b == '0) begin
            state_d = S_DONE;
            quo_d   = '1;
            rem_d   = a;
            dbz_d   = 1'b1;
          end else begin
            state_d = S_RUN;
            d_d     = a;
            b_d     = b;
            p_d     = '0;
            cnt_d   = CNTW'(N);
            dbz_d   = 1'b0;
          end
        end
      end
      S_RUN: begin
        p_d   = step_p;
        d_d   = d_shift;
        cnt_d = cnt_q - CNTW'(1);
        if (cnt_q == CNTW'(1)) begin
          state_d = S_DONE;
          quo_d   = d_shift;
          rem_d   = step_p;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      d_q     <= '0;
      b_q     <= '0;
      p_q     <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      d_q     <= d_d;
      b_q     <= b_d;
      p_q     <= p_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy = (state_q == S_RUN);
  assign done = (state_q == S_DONE);
  assign q    = quo_q;
  assign r    = rem_q;
  assign dbz  = dbz_q;

endmodule

`default_nettype wire
